// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
// The ABORT state only exists when I2C_SEQ_TIMEOUT_EN is defined.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // System clock cycles per SCL period inside the byte engine.
    localparam int I2C_CLK_RATIO = 250;

`ifdef I2C_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_NEXT,
        S_ABORT
    } seq_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_NEXT
    } seq_state_t;
`endif

endpackage

// File: rtl/i2c_txn_sequencer.sv
// I2C transaction sequencer: turns whole transactions (addr, rw, len) into
// byte-by-byte requests for the I2C master byte engine.
// Optional feature: define I2C_SEQ_TIMEOUT_EN for a per-byte timeout that
// aborts the transaction with done+err.
//
// Handshakes: cmd, wr and rd channels all transfer on a cycle where the
// corresponding valid and ready are both 1 at the rising clock edge; a
// producer holds valid and data stable until that edge.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [I2C_DATA_W-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [I2C_DATA_W-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    output logic [I2C_ADDR_W-1:0] m_addr,
    output logic                  m_rw,
    output logic [I2C_DATA_W-1:0] m_tx_data,
    output logic                  m_i2c_en,
    input  logic                  m_ready,
    input  logic [I2C_DATA_W-1:0] m_rx_data
);

    seq_state_t       state;
    logic [LEN_W-1:0] remain;
    logic             m_ready_q;
    logic             ready_seen;
    logic             m_ready_rise;

    assign m_ready_rise = m_ready & ~m_ready_q;
    assign cmd_ready    = (state == S_IDLE);
    // A write byte is consumed in the same cycle FETCH sees it.
    assign wr_ready     = (state == S_FETCH) && !m_rw && wr_valid;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign err = 1'b0;
`endif

    // Registered copy of engine ready for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) m_ready_q <= 1'b0;
        else      m_ready_q <= m_ready;
    end

    // Transaction FSM with all engine- and client-facing outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            remain     <= '0;
            ready_seen <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            m_tx_data  <= '0;
            m_i2c_en   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            err        <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        m_addr     <= cmd_addr;
                        m_rw       <= cmd_rw;
                        remain     <= cmd_len;
                        ready_seen <= 1'b0;
                        // Zero-length transaction completes without touching the bus.
                        if (cmd_len == '0) done  <= 1'b1;
                        else               state <= S_FETCH;
                    end
                end
                S_FETCH: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    if (m_rw) begin
                        state <= S_ISSUE;
                    end else if (wr_valid) begin
                        m_tx_data <= wr_data;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    m_i2c_en <= 1'b1;
                    // The engine has taken the byte once ready was seen high and then low.
                    if (m_ready) begin
                        ready_seen <= 1'b1;
                    end else if (ready_seen) begin
                        ready_seen <= 1'b0;
                        // Keep enable high only to chain another write byte without STOP.
                        m_i2c_en   <= !m_rw && (remain > LEN_W'(1));
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (m_ready_rise) begin
                        ready_seen <= 1'b1;
                        if (m_rw) begin
                            rd_data  <= m_rx_data;
                            rd_valid <= 1'b1;
                            state    <= S_CAPTURE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Bus stays idle until the consumer takes the byte.
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (remain != '0) remain <= remain - LEN_W'(1);
                    if (remain <= LEN_W'(1)) begin
                        done     <= 1'b1;
                        m_i2c_en <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                S_ABORT: begin
                    m_i2c_en <= 1'b0;
                    remain   <= '0;
                    state    <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase

`ifdef I2C_SEQ_TIMEOUT_EN
            // Per-byte watchdog; a byte completing on the deadline cycle still wins.
            if (state == S_ISSUE || state == S_WAIT) begin
                if (to_hit && !(state == S_WAIT && m_ready_rise)) begin
                    m_i2c_en   <= 1'b0;
                    ready_seen <= 1'b0;
                    done       <= 1'b1;
                    err        <= 1'b1;
                    state      <= S_ABORT;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer with a behavioural byte engine that logs bus
// events (START+addr byte, DATA byte, STOP) for the scoreboard.
// Build with I2C_SEQ_TIMEOUT_EN defined to add the timeout scenario.
module tb_i2c_txn_sequencer;

    localparam int BYTE_CYC = 10;
    localparam int GAP_CYC  = 6;
    localparam logic [1:0] EV_START = 2'b01;
    localparam logic [1:0] EV_DATA  = 2'b10;
    localparam logic [1:0] EV_STOP  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [3:0] cmd_len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       done;
    logic       err;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_tx_data;
    logic       m_i2c_en;
    logic       m_ready;
    logic [7:0] m_rx_data;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 64;
`else
    localparam int TO_CYC = 4096;
`endif

    i2c_txn_sequencer #(.LEN_W(4), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .m_addr(m_addr), .m_rw(m_rw), .m_tx_data(m_tx_data), .m_i2c_en(m_i2c_en),
        .m_ready(m_ready), .m_rx_data(m_rx_data)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_bus_q[$];
    logic [7:0] exp_rd_q[$];
    logic [0:0] exp_done_q[$];
    logic [9:0] bus_log_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] slave_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int bus_cnt = 0;
    logic en_seen = 1'b0;
    logic en_clear = 1'b0;
    logic eng_hold = 1'b0;
    logic force_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural byte engine ----------------
    typedef enum logic [1:0] {E_IDLE, E_BYTE, E_GAP} eng_state_t;
    eng_state_t e_st;
    int         e_cnt;
    logic       e_rw;
    logic [7:0] e_tx;
    logic       eng_ready;

    assign m_ready = force_ready ? 1'b1 : eng_ready;

    always @(posedge clk or negedge rst) begin : engine
        logic [7:0] b;
        if (!rst) begin
            e_st      <= E_IDLE;
            e_cnt     <= 0;
            e_rw      <= 1'b0;
            e_tx      <= '0;
            eng_ready <= 1'b1;
            m_rx_data <= '0;
        end else begin
            case (e_st)
                E_IDLE: begin
                    if (m_i2c_en && !eng_hold) begin
                        bus_log_q.push_back({EV_START, m_addr, m_rw});
                        e_rw      <= m_rw;
                        e_tx      <= m_tx_data;
                        eng_ready <= 1'b0;
                        e_cnt     <= BYTE_CYC;
                        e_st      <= E_BYTE;
                    end
                end
                E_BYTE: begin
                    if (e_cnt > 1) begin
                        e_cnt <= e_cnt - 1;
                    end else if (e_rw) begin
                        b = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
                        bus_log_q.push_back({EV_DATA, b});
                        bus_log_q.push_back({EV_STOP, 8'h00});
                        m_rx_data <= b;
                        eng_ready <= 1'b1;
                        e_st      <= E_IDLE;
                    end else begin
                        bus_log_q.push_back({EV_DATA, e_tx});
                        eng_ready <= 1'b1;
                        if (m_i2c_en) begin
                            e_cnt <= GAP_CYC;
                            e_st  <= E_GAP;
                        end else begin
                            bus_log_q.push_back({EV_STOP, 8'h00});
                            e_st <= E_IDLE;
                        end
                    end
                end
                E_GAP: begin
                    eng_ready <= 1'b0;
                    if (e_cnt > 1) begin
                        e_cnt <= e_cnt - 1;
                    end else begin
                        e_tx  <= m_tx_data;
                        e_cnt <= BYTE_CYC;
                        e_st  <= E_BYTE;
                    end
                end
                default: e_st <= E_IDLE;
            endcase
        end
    end

    // ---------------- write-data driver ----------------
    initial begin : wr_driver
        logic fire;
        forever begin
            @(negedge clk);
            fire = wr_valid & wr_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                wr_q.delete();
                wr_valid = 1'b0;
            end else begin
                if (fire) begin
                    wr_valid = 1'b0;
                    wr_cnt++;
                end
                if (!wr_valid && wr_q.size() > 0) begin
                    wr_data  = wr_q.pop_front();
                    wr_valid = 1'b1;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin : bus_monitor
        logic [9:0] ev;
        forever begin
            @(negedge clk);
            while (bus_log_q.size() > 0) begin
                ev = bus_log_q.pop_front();
                bus_cnt++;
                if (exp_bus_q.size() == 0) check("bus_event_unexpected", {22'd0, ev}, 32'hFFFF)
                ;
                else check("bus_event", {22'd0, ev}, {22'd0, exp_bus_q.pop_front()});
            end
        end
    end

    initial begin : out_monitor
        forever begin
            @(negedge clk);
            if (en_clear) en_seen = 1'b0;
            else if (m_i2c_en) en_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else check("done_err", {31'd0, err}, {31'd0, exp_done_q.pop_front()});
            end else if (err) begin
                check("err_without_done", 32'd1, 32'd0);
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd_q.size() == 0) check("rd_unexpected", {24'd0, rd_data}, 32'hFFFF);
                else check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (done_cnt == start) check(name, 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int base_wr;
        int base_bus;
        int n;
        logic hold_en;
        logic hold_valid;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_m_i2c_en", {31'd0, m_i2c_en}, 32'd0);
        check("reset_m_addr", {25'd0, m_addr}, 32'd0);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd0);

        // 1: single-byte write
        exp_bus_q.push_back({EV_START, 8'hA0});
        exp_bus_q.push_back({EV_DATA, 8'hA5});
        exp_bus_q.push_back({EV_STOP, 8'h00});
        exp_done_q.push_back(1'b0);
        base_wr = wr_cnt;
        wr_q.push_back(8'hA5);
        send_cmd(7'h50, 1'b0, 4'd1);
        check("w1_m_addr", {25'd0, m_addr}, 32'h50);
        wait_done("w1_done_timeout", 500);
        check("w1_wr_pulses", wr_cnt - base_wr, 32'd1);

        // 2: three-byte chained write
        exp_bus_q.push_back({EV_START, 8'hA0});
        exp_bus_q.push_back({EV_DATA, 8'h11});
        exp_bus_q.push_back({EV_DATA, 8'h22});
        exp_bus_q.push_back({EV_DATA, 8'h33});
        exp_bus_q.push_back({EV_STOP, 8'h00});
        exp_done_q.push_back(1'b0);
        base_wr = wr_cnt;
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        wr_q.push_back(8'h33);
        send_cmd(7'h50, 1'b0, 4'd3);
        wait_done("w3_done_timeout", 1000);
        check("w3_wr_pulses", wr_cnt - base_wr, 32'd3);

        // 3: two-byte read with back-pressure on the first byte
        slave_q.push_back(8'h5A);
        slave_q.push_back(8'hC3);
        exp_bus_q.push_back({EV_START, 8'h79});
        exp_bus_q.push_back({EV_DATA, 8'h5A});
        exp_bus_q.push_back({EV_STOP, 8'h00});
        exp_bus_q.push_back({EV_START, 8'h79});
        exp_bus_q.push_back({EV_DATA, 8'hC3});
        exp_bus_q.push_back({EV_STOP, 8'h00});
        exp_rd_q.push_back(8'h5A);
        exp_rd_q.push_back(8'hC3);
        exp_done_q.push_back(1'b0);
        rd_ready = 1'b0;
        send_cmd(7'h3C, 1'b1, 4'd2);
        n = 0;
        while (!rd_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rd_first_valid", {31'd0, rd_valid}, 32'd1);
        base_bus   = bus_cnt;
        hold_en    = 1'b0;
        hold_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (m_i2c_en) hold_en = 1'b1;
            if (!rd_valid) hold_valid = 1'b0;
        end
        check("rd_hold_bus_idle", bus_cnt - base_bus, 32'd0);
        check("rd_hold_no_enable", {31'd0, hold_en}, 32'd0);
        check("rd_hold_valid_held", {31'd0, hold_valid}, 32'd1);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        wait_done("rd_done_timeout", 1000);

        // 4: zero-length command
        en_clear = 1'b1;
        @(negedge clk);
        en_clear = 1'b0;
        exp_done_q.push_back(1'b0);
        send_cmd(7'h22, 1'b0, 4'd0);
        @(negedge clk);
        check("len0_done_next_cycle", {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
        check("len0_no_enable", {31'd0, en_seen}, 32'd0);
        check("len0_cmd_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
        // 5: engine never leaves idle -> timeout abort
        eng_hold    = 1'b1;
        force_ready = 1'b1;
        exp_done_q.push_back(1'b1);
        send_cmd(7'h10, 1'b1, 4'd2);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 32'd66);
        check("timeout_err", {31'd0, err}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("timeout_back_idle", {31'd0, cmd_ready}, 32'd1);
        check("timeout_en_low", {31'd0, m_i2c_en}, 32'd0);
        force_ready = 1'b0;
        eng_hold    = 1'b0;
`endif

        // 6: reset during byte 2 of a three-byte write
        exp_bus_q.push_back({EV_START, 8'hA0});
        exp_bus_q.push_back({EV_DATA, 8'h11});
        base_wr = wr_cnt;
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        wr_q.push_back(8'h33);
        send_cmd(7'h50, 1'b0, 4'd3);
        n = 0;
        while (wr_cnt - base_wr < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_second_fetch", wr_cnt - base_wr, 32'd2);
        repeat (3) @(negedge clk);
        check("rst_mid_en_before", {31'd0, m_i2c_en}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_en", {31'd0, m_i2c_en}, 32'd0);
        check("rst_mid_addr", {25'd0, m_addr}, 32'd0);
        check("rst_mid_tx", {24'd0, m_tx_data}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // post-reset write proves recovery
        exp_bus_q.push_back({EV_START, 8'hA0});
        exp_bus_q.push_back({EV_DATA, 8'h7E});
        exp_bus_q.push_back({EV_STOP, 8'h00});
        exp_done_q.push_back(1'b0);
        wr_q.push_back(8'h7E);
        send_cmd(7'h50, 1'b0, 4'd1);
        wait_done("post_rst_done_timeout", 500);

        repeat (30) @(negedge clk);
        check("exp_bus_drained", exp_bus_q.size(), 32'd0);
        check("exp_rd_drained", exp_rd_q.size(), 32'd0);
        check("exp_done_drained", exp_done_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
